// File: rtl/uart_rx_param_if.sv
// Received-word handshake between the UART receiver and its consumer.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: internal bit timing, 3-sample majority vote at mid-bit,
// framing/parity/overrun reporting and a valid/ready output register.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  uart_rx_param_if.master out_if
);

  localparam logic [15:0] CntLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CntMid   = 16'(CLKS_PER_BIT / 2);
  localparam logic [3:0]  DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]  StopLast = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frm_err_q, frm_err_d;
  logic                 par_err_q, par_err_d;
  logic                 sync1_q, sync2_q;
  logic [2:0]           hist_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, fe_q, pe_q, ovr_q;
  logic                 vote, fall, at_mid, at_end, done;

  assign vote   = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign fall   = hist_q[0] & ~sync2_q;
  assign at_mid = (cnt_q == CntMid);
  assign at_end = (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[1:0], sync2_q};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = at_end ? 16'd0 : cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    frm_err_d = frm_err_q;
    par_err_d = par_err_q;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 16'd0;
        if (fall) begin
          state_d   = StStart;
          bit_idx_d = 4'd0;
          frm_err_d = 1'b0;
          par_err_d = 1'b0;
        end
      end
      StStart: begin
        if (at_mid && vote) begin
          state_d = StIdle;
          cnt_d   = 16'd0;
        end else if (at_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (at_mid) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (at_end) begin
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == DataLast) begin
            bit_idx_d = 4'd0;
            state_d   = (PARITY != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (at_mid) par_err_d = (PARITY == 1) ? ~(^shift_q ^ vote) : (^shift_q ^ vote);
        if (at_end) state_d = StStop;
      end
      StStop: begin
        if (at_mid) begin
          if (!vote) frm_err_d = 1'b1;
          // Finish at the last stop sample so a short stop bit cannot swallow the next start.
          if (bit_idx_q == StopLast) begin
            done    = 1'b1;
            state_d = StIdle;
            cnt_d   = 16'd0;
          end
        end else if (at_end) begin
          bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      bit_idx_q <= 4'd0;
      shift_q   <= '0;
      frm_err_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      frm_err_q <= frm_err_d;
      par_err_q <= par_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= done && valid_q && !out_if.rx_ready;
      if (done && (!valid_q || out_if.rx_ready)) begin
        data_q  <= shift_q;
        fe_q    <= frm_err_q | ~vote;
        pe_q    <= par_err_q;
        valid_q <= 1'b1;
      end else if (valid_q && out_if.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.rx_data    = data_q;
  assign out_if.rx_valid   = valid_q;
  assign out_if.frame_err  = fe_q;
  assign out_if.parity_err = pe_q;
  assign out_if.overrun    = ovr_q;
  assign out_if.busy       = (state_q != StIdle);

endmodule
